// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port sdram request arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  localparam int NUM_PORTS = 3;
  localparam int P_VID = 0;
  localparam int P_CPU = 1;
  localparam int P_AUX = 2;

  localparam int STARVE_MAX_DEF = 8;
  localparam int TIMEOUT_DEF    = 63;

  typedef struct packed {
    logic        we;
    logic        burst;
    logic [25:0] addr;
    logic [15:0] wdata;
    logic [1:0]  bs;
  } mem_req_t;
endpackage

// File: rtl/sdram_arbiter_pick.sv
// Combinational winner select: a starved CPU/AUX port pre-empts, otherwise lowest index wins.
module arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] starved,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 valid
);
  always_comb begin
    grant = '0;
    if (req[P_CPU] && starved[P_CPU]) begin
      grant[P_CPU] = 1'b1;
    end else if (req[P_AUX] && starved[P_AUX]) begin
      grant[P_AUX] = 1'b1;
    end else begin
      // Descending scan so the lowest pending index is the last write.
      for (int i = NUM_PORTS-1; i >= 0; i--) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

  assign valid = |req;
endmodule

// File: rtl/sdram_arbiter.sv
// Three-port fixed-priority arbiter with starvation promotion and acceptance timeout,
// driving a single sdram controller request interface.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        nRESET,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS-1:0]        burst,
  input  logic [NUM_PORTS-1:0][25:0]  addr,
  input  logic [NUM_PORTS-1:0][15:0]  wdata,
  input  logic [NUM_PORTS-1:0][1:0]   bs,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [63:0]                 rdata,
  output logic                        err,
  output logic                        mem_sel,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic                        mem_burst,
  output logic [25:0]                 mem_addr,
  output logic [15:0]                 mem_din,
  output logic [1:0]                  mem_bs,
  input  logic                        mem_ready,
  input  logic [63:0]                 mem_dout
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t               state;
  logic [NUM_PORTS-1:0] gnt;
  logic [TW-1:0]        tcnt;
  logic [NUM_PORTS-1:0] starved, pick;
  logic                 pick_vld, issue;
  mem_req_t             sel_req;

  arb_pick u_pick (.req(req), .starved(starved), .grant(pick), .valid(pick_vld));

  // No issue in the ack cycle: the finishing requester still holds req then.
  assign issue = (state == IDLE) && pick_vld && mem_ready && (ack == '0);

  assign starved[P_VID] = 1'b0;
  for (genvar p = 1; p < NUM_PORTS; p++) begin : g_starve
    logic [SW-1:0] cnt;
    assign starved[p] = (cnt == SW'(STARVE_MAX));
    always_ff @(posedge clk) begin
      if (!nRESET || !req[p])
        cnt <= '0;
      else if (issue)
        cnt <= pick[p] ? '0 : (starved[p] ? cnt : cnt + SW'(1));
    end
  end

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick[i]) begin
        sel_req.we    = we[i];
        sel_req.burst = burst[i] & ~we[i];
        sel_req.addr  = addr[i];
        sel_req.wdata = wdata[i];
        sel_req.bs    = bs[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state     <= IDLE;
      gnt       <= '0;
      tcnt      <= '0;
      ack       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_sel   <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_burst <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_bs    <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (issue) begin
          gnt       <= pick;
          mem_sel   <= 1'b1;
          mem_rd    <= ~sel_req.we;
          mem_wr    <= sel_req.we;
          mem_burst <= sel_req.burst;
          mem_addr  <= sel_req.addr;
          mem_din   <= sel_req.wdata;
          mem_bs    <= sel_req.bs;
          tcnt      <= '0;
          state     <= ISSUE;
        end
        ISSUE: if (!mem_ready) begin
          mem_sel <= 1'b0;
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          state   <= BUSY;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          // Controller never took it: release the bus and complete the requester with an error.
          mem_sel   <= 1'b0;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_burst <= 1'b0;
          mem_addr  <= '0;
          mem_din   <= '0;
          mem_bs    <= '0;
          err       <= 1'b1;
          ack       <= gnt;
          state     <= IDLE;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
        BUSY: if (mem_ready) begin
          rdata <= mem_dout;
          ack   <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: mock controller, transaction-level arbitration model, per-cycle monitor.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  logic clk = 1'b0, nRESET = 1'b0;
  logic [2:0] req = '0, we = '0, burst = '0;
  logic [2:0][25:0] addr = '0;
  logic [2:0][15:0] wdata = '0;
  logic [2:0][1:0] bs = '0;
  logic [2:0] ack;
  logic [63:0] rdata;
  logic err, mem_sel, mem_rd, mem_wr, mem_burst;
  logic [25:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0] mem_bs;
  logic mem_ready = 1'b1;
  logic [63:0] mem_dout = '0;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.STARVE_MAX(8), .TIMEOUT(63)) dut (
    .clk(clk), .nRESET(nRESET), .req(req), .we(we), .burst(burst), .addr(addr),
    .wdata(wdata), .bs(bs), .ack(ack), .rdata(rdata), .err(err),
    .mem_sel(mem_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_burst(mem_burst),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_bs(mem_bs),
    .mem_ready(mem_ready), .mem_dout(mem_dout)
  );

  function automatic logic [63:0] mword(input logic [25:0] a);
    return {4{a[15:0]}} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mock controller: accepts after acc_dly cycles of sel, stays busy lat cycles.
  int acc_dly = 0, lat = 6, m_busy = 0, m_wait = 0;
  bit never_accept = 0;
  logic [25:0] m_addr = '0;
  always @(posedge clk) begin
    if (m_busy > 0) begin
      if (m_busy == 1) begin
        mem_ready <= 1'b1;
        mem_dout  <= mword(m_addr);
      end
      m_busy <= m_busy - 1;
    end else if (mem_sel && mem_ready && !never_accept) begin
      if (m_wait >= acc_dly) begin
        mem_ready <= 1'b0;
        m_busy    <= lat;
        m_addr    <= mem_addr;
        m_wait    <= 0;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else begin
      m_wait <= 0;
    end
  end

  // Monitor: samples on negedge; prev_* hold what the DUT sampled at the edge just passed.
  logic prev_nrst = 1'b0, prev_sel = 1'b0, prev_ready = 1'b1;
  logic [2:0] prev_req = '0;
  int scnt [3] = '{default:0};
  int inflt = -1, sel_cyc = 0;
  bit accepted = 0, ack_due = 0, exp_err = 0, iss_rd = 0, iss_burst = 0;
  logic [25:0] iss_addr = '0;
  int grants[$];

  always @(negedge clk) begin : mon
    logic [2:0] exp_ack;
    logic [63:0] ew, msk;
    int w;
    bit issued;
    if (!prev_nrst) begin
      chk("reset_outputs", {ack, rdata, err, mem_sel, mem_rd, mem_wr, mem_burst, mem_addr, mem_din, mem_bs}, '0);
      inflt = -1; ack_due = 0; exp_err = 0; scnt = '{default:0};
    end else begin
      exp_ack = '0;
      issued = mem_sel && !prev_sel;
      if (issued) begin
        chk("issue_needs_ready", prev_ready, 1);
        chk("issue_needs_free_bus", inflt < 0, 1);
        chk("issue_needs_req", |prev_req, 1);
        if (prev_req[1] && scnt[1] == 8)      w = 1;
        else if (prev_req[2] && scnt[2] == 8) w = 2;
        else if (prev_req[0])                 w = 0;
        else if (prev_req[1])                 w = 1;
        else                                  w = 2;
        chk("issue_payload", {mem_rd, mem_wr, mem_burst, mem_addr, mem_din, mem_bs},
            {~we[w], we[w], burst[w] & ~we[w], addr[w], wdata[w], bs[w]});
        inflt = w; iss_addr = addr[w]; iss_rd = !we[w]; iss_burst = burst[w] && !we[w];
        accepted = 0; sel_cyc = 0;
        grants.push_back(w);
      end
      for (int p = 1; p < 3; p++) begin
        if (!prev_req[p])  scnt[p] = 0;
        else if (issued)   scnt[p] = (p == w) ? 0 : ((scnt[p] < 8) ? scnt[p] + 1 : 8);
      end
      if (inflt >= 0 && !accepted && mem_sel) begin
        sel_cyc++;
        if (!mem_ready) accepted = 1;
      end
      if (ack_due) begin
        exp_ack = 3'b001 << inflt;
        if (iss_rd) begin
          ew  = mword(iss_addr);
          msk = iss_burst ? '1 : 64'hFFFF;
          chk("read_data", rdata & msk, ew & msk);
        end
        inflt = -1; ack_due = 0;
      end else if (inflt >= 0 && !accepted && !mem_sel) begin
        chk("timeout_issue_cycles", sel_cyc, 63);
        chk("timeout_mem_dropped", {mem_rd, mem_wr, mem_burst}, 0);
        exp_ack = 3'b001 << inflt;
        exp_err = 1; inflt = -1;
      end
      chk("ack", ack, exp_ack);
      chk("err", err, exp_err);
      if (inflt >= 0 && accepted && mem_ready && !prev_ready) ack_due = 1;
    end
    prev_nrst = nRESET; prev_sel = mem_sel; prev_ready = mem_ready; prev_req = req;
  end

  task automatic wait_ack(input int p, input int budget);
    int n = 0;
    while (!ack[p] && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk($sformatf("ack_wait_p%0d", p), ack[p], 1);
  endtask

  task automatic do_req(input int p, input logic w, input logic b, input logic [25:0] a,
                        input logic [15:0] d, input logic [1:0] s, input int budget);
    we[p] = w; burst[p] = b; addr[p] = a; wdata[p] = d; bs[p] = s; req[p] = 1'b1;
    wait_ack(p, budget);
    req[p] = 1'b0;
  endtask

  initial begin : stim
    int g0, n;
    repeat (2) @(posedge clk);
    #2 nRESET = 1'b1;
    @(posedge clk); #2;

    // Single read, controller holds off acceptance for a couple of cycles
    acc_dly = 2;
    do_req(1, 1'b0, 1'b0, 26'h000100, 16'h0, 2'b11, 200);
    chk("single_rdata_lit", rdata[15:0], 16'hCCEF);
    acc_dly = 0;
    @(posedge clk); #2;

    // Contention: all three at once
    g0 = grants.size();
    fork
      do_req(0, 1'b0, 1'b1, 26'h002000, 16'h0, 2'b11, 400);
      do_req(1, 1'b0, 1'b0, 26'h003001, 16'h0, 2'b11, 400);
      do_req(2, 1'b0, 1'b0, 26'h000777, 16'h0, 2'b11, 400);
    join
    chk("contention_count", grants.size() - g0, 3);
    for (int i = 0; i < 3 && g0 + i < grants.size(); i++) chk("contention_order", grants[g0+i], i);
    @(posedge clk); #2;

    // Starvation: port0 re-requests continuously while port2 waits
    g0 = grants.size();
    we[0] = 1'b0; burst[0] = 1'b0; addr[0] = 26'h000040; bs[0] = 2'b11; req[0] = 1'b1;
    do_req(2, 1'b0, 1'b0, 26'h000555, 16'h0, 2'b11, 2000);
    req[0] = 1'b0;
    chk("starve_count", grants.size() - g0, 9);
    for (int i = 0; i < 9 && g0 + i < grants.size(); i++)
      chk("starve_order", grants[g0+i], (i == 8) ? 2 : 0);
    @(posedge clk); #2;

    // Write on port 2; burst must be suppressed
    fork
      do_req(2, 1'b1, 1'b1, 26'h001234, 16'hABCD, 2'b10, 200);
      begin
        n = 0;
        while (!mem_sel && n < 50) begin @(posedge clk); #2; n++; end
        chk("write_issue_lit", {mem_sel, mem_wr, mem_rd, mem_burst, mem_bs, mem_din, mem_addr},
            {1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 16'hABCD, 26'h001234});
      end
    join
    @(posedge clk); #2;

    // Timeout: controller never accepts
    never_accept = 1;
    do_req(1, 1'b0, 1'b0, 26'h000BAD, 16'h0, 2'b11, 200);
    chk("timeout_lit", {err, mem_rd, mem_sel, ack}, {1'b1, 1'b0, 1'b0, 3'b010});
    never_accept = 0;
    repeat (3) @(posedge clk); #2;
    chk("err_sticky", err, 1);
    do_req(0, 1'b0, 1'b0, 26'h000ACE, 16'h0, 2'b11, 200);
    chk("after_timeout_rdata", rdata[15:0], 16'h0ACE ^ 16'hCDEF);
    @(posedge clk); #2;

    // Reset while the controller is busy
    lat = 12;
    we[1] = 1'b0; burst[1] = 1'b0; addr[1] = 26'h000321; bs[1] = 2'b11; req[1] = 1'b1;
    n = 0;
    while (!mem_sel && n < 50) begin @(posedge clk); #2; n++; end
    while ((mem_sel || mem_ready) && n < 100) begin @(posedge clk); #2; n++; end
    chk("reached_busy", {mem_sel, mem_ready}, 2'b00);
    nRESET = 1'b0;
    @(posedge clk); #2;
    nRESET = 1'b1;
    chk("reset_mid_busy", {ack, err, mem_sel, mem_rd, mem_wr, rdata}, '0);
    n = 0;
    while (!mem_ready && n < 50) begin
      chk("no_issue_while_ctrl_busy", mem_sel, 0);
      @(posedge clk); #2;
      n++;
    end
    wait_ack(1, 200);
    req[1] = 1'b0;
    lat = 6;

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
